pipeline_trace_buffer: RTL and testbench
========================================

# pipeline_trace_buffer

Synthesisable retirement-trace recorder for the 5-stage RISC-V datapath, sitting beside the WB stage. Each cycle it can capture one retiring record (PC, instruction, destination register, write-back data, RegWrite) into a circular buffer of parametrised depth. It supports wrap, stop-when-full and PC-triggered capture, plus saturating cycle, retire and stall counters. Captured records are drained oldest-first over a valid/ready stream once capture ends.

## Interface
- XLEN, 32, data/PC/instruction width
- DEPTH, 16, buffer entries; power of two, ≥2
- CNT_W, 32, performance counter width
- AW = log2(DEPTH) (derived, not overridable)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset sampled on rising edge
- mode  in  2  00 wrap, 01 stop-when-full, 10 trigger, 11 treated as 00; sampled only on arm
- arm  in  1  start new capture (pulse)
- stop  in  1  force end of capture
- trig_pc  in  XLEN  trigger PC (mode 10); sampled on arm
- post_count  in  AW+1  records to capture after trigger record; sampled on arm; values >DEPTH-1 clamp to DEPTH-1
- rec_valid  in  1  a record retires this cycle
- rec_pc, rec_instr, rec_wdata  in  XLEN each  record fields
- rec_rd  in  5  destination register
- rec_regwrite  in  1  record RegWrite
- stall_in  in  1  pipeline stall this cycle
- out_valid  out  1  oldest entry available
- out_ready  in  1  consumer accepts
- out_pc, out_instr, out_wdata  out  XLEN  oldest entry fields
- out_rd  out  5; out_regwrite  out  1
- state  out  2  IDLE=00, CAPTURE=01, POST=10, DONE=11
- count  out  AW+1  stored entries
- overflow  out  1  an entry was overwritten in this capture
- triggered  out  1  trigger matched in this capture
- cycle_cnt, retire_cnt, stall_cnt  out  CNT_W each

## Operation
- Reset: state=IDLE, pointers=0, count=0, overflow=0, triggered=0, all counters=0, out_valid=0. Buffer contents are don't-care.
- arm (any state, highest priority): next state CAPTURE. Clears pointers, count, overflow, triggered and counters. Latches mode, trig_pc and post_count. A record presented in the arm cycle is not captured.
- CAPTURE/POST: each rec_valid writes the record at wr_ptr, wr_ptr+1 mod DEPTH.
  - If count<DEPTH, count+1.
  - If count==DEPTH (modes wrap/trigger), the oldest entry is overwritten, rd_ptr+1 and overflow=1.
- Mode 01: the write that makes count==DEPTH moves state to DONE. No overwrite ever occurs.
- Mode 10, CAPTURE: a rec_valid with rec_pc==trig_pc captures the record and sets triggered=1.
  - post_count==0 → DONE; otherwise → POST with remaining=post_count.
- POST: each captured record decrements remaining; the write that reaches 0 moves state to DONE. trig_pc matches in POST are ignored.
- stop in CAPTURE/POST → DONE. A simultaneous rec_valid record is still captured. stop in IDLE/DONE has no effect.
- Counters run in CAPTURE/POST only, and saturate at all-ones.
  - cycle_cnt +1 every cycle.
  - retire_cnt +1 per rec_valid.
  - stall_cnt +1 per stall_in.
- DONE: out_valid=(count!=0). out_* show the entry at rd_ptr (first-word fall-through). out_valid&&out_ready pops: rd_ptr+1, count-1. The state stays DONE when count reaches 0. rec_valid is ignored.
- IDLE/CAPTURE/POST: out_valid=0; out_ready is ignored.

## Timing
- All state, pointers and counters update on the rising edge. reset and arm take effect at that edge.
- Capture latency: a record with rec_valid at edge N is in the buffer and reflected in count after edge N.
- DONE is entered at the edge that captures the terminating record, or at the stop edge. out_valid is high the following cycle.
- Readout: one entry per cycle at full throughput. out_* change only on a pop edge or an arm edge.
- Reset mid-capture or mid-drain aborts to IDLE with all outputs at reset values.
- Wrap-around: pointers wrap DEPTH-1→0. count is never greater than DEPTH.

## Test plan
- DEPTH=4, mode 01, arm, then 6 records with PCs 0x0,0x4,…,0x14 → DONE after the 4th record, count=4. Drain yields PCs 0x0..0xC, overflow=0, retire_cnt=4.
- Mode 00, arm, 6 records, then stop → count=4, overflow=1. Drain yields 0x8,0xC,0x10,0x14.
- Mode 10, trig_pc=0x10, post_count=2, PCs 0x0..0x20 step 4 → triggered=1. DONE after PC 0x18. Drain yields 0xC,0x10,0x14,0x18.
- stall_in high 3 of 10 capture cycles, then stop → cycle_cnt=10, stall_cnt=3. Counters frozen in DONE.
- Drain with out_ready toggling 1,0,1,1 → pops only on ready cycles; out_valid drops when count=0. Asserting arm mid-drain → CAPTURE, count=0.
- reset asserted during POST → state=00, count=0, out_valid=0, all counters 0.

Source files
------------

// File: rtl/pipeline_trace_buffer_if.sv
// Retirement-record input stream and oldest-first readout stream of the trace buffer.
interface pipeline_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            rec_valid;
  logic [XLEN-1:0] rec_pc;
  logic [XLEN-1:0] rec_instr;
  logic [4:0]      rec_rd;
  logic [XLEN-1:0] rec_wdata;
  logic            rec_regwrite;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_wdata;
  logic            out_regwrite;

  modport master (
    output rec_valid, rec_pc, rec_instr, rec_rd, rec_wdata, rec_regwrite, out_ready,
    input  out_valid, out_pc, out_instr, out_rd, out_wdata, out_regwrite
  );

  modport slave (
    input  rec_valid, rec_pc, rec_instr, rec_rd, rec_wdata, rec_regwrite, out_ready,
    output out_valid, out_pc, out_instr, out_rd, out_wdata, out_regwrite
  );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular retirement-trace recorder beside WB: wrap / stop-when-full / PC-trigger
// capture, saturating perf counters, and first-word-fall-through drain once DONE.
module pipeline_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic [$clog2(DEPTH):0]   post_count,
  input  logic                     stall_in,
  pipeline_trace_buffer_if.slave   trc,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     triggered,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 3 * XLEN + 6;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = DEPTH_C - 1'b1;

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_CAPTURE = 2'b01, S_POST = 2'b10, S_DONE = 2'b11} state_e;
  typedef enum logic [1:0] {M_WRAP = 2'b00, M_STOP = 2'b01, M_TRIG = 2'b10} mode_e;

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [XLEN-1:0] trig_pc_q, trig_pc_d;
  logic [AW:0]     post_q, post_d;
  logic [AW:0]     rem_q, rem_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d, trig_q, trig_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, stl_q, stl_d;
  logic            mem_we;
  logic            pop;
  logic [RW-1:0]   mem_q [DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign trc.out_valid = (state_q == S_DONE) && (count_q != '0);
  assign pop           = trc.out_valid && trc.out_ready;
  assign {trc.out_pc, trc.out_instr, trc.out_wdata, trc.out_rd, trc.out_regwrite} = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    trig_pc_d = trig_pc_q;
    post_d    = post_q;
    rem_d     = rem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    trig_d    = trig_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    stl_d     = stl_q;
    mem_we    = 1'b0;
    if (arm) begin
      state_d   = S_CAPTURE;
      mode_d    = (mode == 2'b11) ? M_WRAP : mode_e'(mode);
      trig_pc_d = trig_pc;
      post_d    = (post_count > LAST_C) ? LAST_C : post_count;
      rem_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
      trig_d    = 1'b0;
      cyc_d     = '0;
      ret_d     = '0;
      stl_d     = '0;
    end else begin
      case (state_q)
        S_CAPTURE, S_POST: begin
          cyc_d = sat_inc(cyc_q);
          if (stall_in) stl_d = sat_inc(stl_q);
          if (trc.rec_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            ret_d    = sat_inc(ret_q);
            // Full buffer: the write lands on the oldest slot, so the read side advances with it.
            if (count_q == DEPTH_C) begin
              rd_ptr_d = rd_ptr_q + 1'b1;
              ovf_d    = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
            if (mode_q == M_STOP && count_q == LAST_C) state_d = S_DONE;
            if (state_q == S_CAPTURE && mode_q == M_TRIG && trc.rec_pc == trig_pc_q) begin
              trig_d = 1'b1;
              if (post_q == '0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_POST;
                rem_d   = post_q;
              end
            end
            if (state_q == S_POST) begin
              rem_d = rem_q - 1'b1;
              if (rem_q == (AW + 1)'(1)) state_d = S_DONE;
            end
          end
          if (stop) state_d = S_DONE;
        end
        S_DONE: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= M_WRAP;
      trig_pc_q <= '0;
      post_q    <= '0;
      rem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      trig_q    <= 1'b0;
      cyc_q     <= '0;
      ret_q     <= '0;
      stl_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      trig_pc_q <= trig_pc_d;
      post_q    <= post_d;
      rem_q     <= rem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      trig_q    <= trig_d;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      stl_q     <= stl_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q] <= {trc.rec_pc, trc.rec_instr, trc.rec_wdata, trc.rec_rd, trc.rec_regwrite};
    end
  end

  assign state      = state_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign triggered  = trig_q;
  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
  assign stall_cnt  = stl_q;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Scoreboard bench for pipeline_trace_buffer at DEPTH=4: expected drain order is
// queued as records are driven and popped as the DUT hands entries out.
module tb_pipeline_trace_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        arm, stop, stall_in;
  logic [31:0] trig_pc;
  logic [2:0]  post_count;
  logic [1:0]  state;
  logic [2:0]  count;
  logic        overflow, triggered;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt;

  pipeline_trace_buffer_if #(.XLEN(32)) trc ();

  pipeline_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .mode(mode), .arm(arm), .stop(stop),
    .trig_pc(trig_pc), .post_count(post_count), .stall_in(stall_in), .trc(trc),
    .state(state), .count(count), .overflow(overflow), .triggered(triggered),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb[$];
  int          m_st, m_mode, m_post, m_rem;
  logic [31:0] m_trig_pc;
  bit          m_ovf, m_trigd;
  int          m_cyc, m_ret, m_stl;

  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction
  function automatic logic [31:0] f_wdata(input logic [31:0] pc);
    return ~pc + 32'h11;
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] pc);
    return pc[6:2];
  endfunction
  function automatic logic f_rw(input logic [31:0] pc);
    return pc[2] ^ pc[4];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"}, 64'(state), 64'(m_st));
    check({tag, "_count"}, 64'(count), 64'(sb.size()));
    check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    check({tag, "_trig"}, 64'(triggered), 64'(m_trigd));
    check({tag, "_cyc"}, 64'(cycle_cnt), 64'(m_cyc));
    check({tag, "_ret"}, 64'(retire_cnt), 64'(m_ret));
    check({tag, "_stl"}, 64'(stall_cnt), 64'(m_stl));
    check({tag, "_ovalid"}, 64'(trc.out_valid), 64'(m_st == 3 && sb.size() != 0));
  endtask

  task automatic model_clear();
    sb.delete();
    m_ovf = 0; m_trigd = 0; m_cyc = 0; m_ret = 0; m_stl = 0; m_rem = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    m_st = 0;
  endtask

  task automatic arm_cfg(input logic [1:0] md, input logic [31:0] tpc, input logic [2:0] post);
    arm = 1'b1; mode = md; trig_pc = tpc; post_count = post;
    trc.rec_valid = 1'b1; trc.rec_pc = tpc;
    @(posedge clock); #1;
    arm = 1'b0; trc.rec_valid = 1'b0; mode = 2'b00;
    model_clear();
    m_st      = 1;
    m_mode    = (md == 2'b11) ? 0 : int'(md);
    m_trig_pc = tpc;
    m_post    = (int'(post) > DEPTH - 1) ? DEPTH - 1 : int'(post);
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input bit stp, input bit stl);
    int nst;
    trc.rec_valid    = v;
    trc.rec_pc       = pc;
    trc.rec_instr    = f_instr(pc);
    trc.rec_wdata    = f_wdata(pc);
    trc.rec_rd       = f_rd(pc);
    trc.rec_regwrite = f_rw(pc);
    stop = stp; stall_in = stl;
    nst = m_st;
    if (m_st == 1 || m_st == 2) begin
      m_cyc++;
      if (stl) m_stl++;
      if (v) begin
        m_ret++;
        sb.push_back(pc);
        if (sb.size() > DEPTH) begin
          void'(sb.pop_front());
          m_ovf = 1;
        end
        if (m_mode == 1 && sb.size() == DEPTH) nst = 3;
        if (m_st == 1 && m_mode == 2 && pc == m_trig_pc) begin
          m_trigd = 1;
          if (m_post == 0) nst = 3;
          else begin nst = 2; m_rem = m_post; end
        end else if (m_st == 2) begin
          m_rem--;
          if (m_rem == 0) nst = 3;
        end
      end
      if (stp) nst = 3;
    end
    m_st = nst;
    @(posedge clock); #1;
    trc.rec_valid = 1'b0; stop = 1'b0; stall_in = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [3:0] pat, input int plen, input int maxcyc);
    logic [31:0] e;
    for (int i = 0; i < maxcyc && sb.size() > 0; i++) begin
      trc.out_ready = pat[i % plen];
      check({tag, "_dcount"}, 64'(count), 64'(sb.size()));
      check({tag, "_dvalid"}, 64'(trc.out_valid), 64'(1));
      if (trc.out_ready) begin
        e = sb.pop_front();
        check({tag, "_pc"}, 64'(trc.out_pc), 64'(e));
        check({tag, "_instr"}, 64'(trc.out_instr), 64'(f_instr(e)));
        check({tag, "_wdata"}, 64'(trc.out_wdata), 64'(f_wdata(e)));
        check({tag, "_rd"}, 64'(trc.out_rd), 64'(f_rd(e)));
        check({tag, "_rw"}, 64'(trc.out_regwrite), 64'(f_rw(e)));
      end
      @(posedge clock); #1;
    end
    trc.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mode = '0; arm = 0; stop = 0; stall_in = 0; trig_pc = '0; post_count = '0;
    trc.rec_valid = 0; trc.rec_pc = '0; trc.rec_instr = '0; trc.rec_rd = '0;
    trc.rec_wdata = '0; trc.rec_regwrite = 0; trc.out_ready = 0;
    @(posedge clock); #1;
    do_reset();
    check_model("reset");

    // stop-when-full: DONE on the 4th record, later records ignored
    arm_cfg(2'b01, 32'h0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      step(1, 32'(i * 4), 0, 0);
      if (i == 3) check("full_state", 64'(state), 64'(3));
    end
    check_model("full");
    drain("full", 4'b1111, 4, 20);
    check_model("full_end");

    // wrap with overwrite, then stop
    arm_cfg(2'b00, 32'h0, 3'd0);
    for (int i = 0; i < 6; i++) step(1, 32'(i * 4), 0, 0);
    step(0, 32'h0, 1, 0);
    check_model("wrap");
    drain("wrap", 4'b1111, 4, 20);
    check_model("wrap_end");

    // trigger at 0x10 with two post records, then arm mid-drain
    arm_cfg(2'b10, 32'h10, 3'd2);
    for (int i = 0; i < 9; i++) step(1, 32'(i * 4), 0, 0);
    check_model("trig");
    drain("trig", 4'b1111, 4, 2);
    check_model("trig_part");
    arm_cfg(2'b00, 32'h0, 3'd0);
    check_model("rearm");

    // counters: 10 capture cycles, stall on 3, stop on the last
    for (int i = 0; i < 10; i++)
      step((i % 2) == 1 && i < 8, 32'h100 + 32'(i * 4), i == 9, i == 0 || i == 3 || i == 6);
    check_model("cnt");
    check("cnt_cyc10", 64'(cycle_cnt), 64'(10));
    check("cnt_stl3", 64'(stall_cnt), 64'(3));
    for (int i = 0; i < 3; i++) step(1, 32'h200, 1, 1);
    check_model("cnt_frozen");
    drain("toggle", 4'b1101, 4, 20);
    check_model("toggle_end");

    // mode 11 behaves as wrap
    arm_cfg(2'b11, 32'h0, 3'd0);
    for (int i = 0; i < 5; i++) step(1, 32'h40 + 32'(i * 4), 0, 0);
    step(0, 32'h0, 1, 0);
    check_model("m11");
    drain("m11", 4'b1111, 4, 20);

    // post_count 7 clamps to 3
    arm_cfg(2'b10, 32'h8, 3'd7);
    for (int i = 0; i < 8; i++) step(1, 32'(i * 4), 0, 0);
    check_model("clamp");
    drain("clamp", 4'b1111, 4, 20);
    check_model("clamp_end");

    // reset in POST
    arm_cfg(2'b10, 32'h8, 3'd3);
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 1);
    check_model("post");
    do_reset();
    check_model("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
